dot_level_controller: RTL and testbench

//  Sequences the 12x12 maze dot bitmap across a game: serially loads the start map, clears dots Pac-Man eats
//  on tile-aligned positions, keeps score/remaining count, and detects level clear. After a hold it reloads
//  the map and advances the level. Sits between the movement logic (pacX/pacY) and the dot renderer (dot_map).

---
 rtl/dot_level_controller.sv | 182 ++++++++++++++++++
 tb/tb_dot_level_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_level_controller.sv
// Maze dot sequencer: serial map load, dot eating, score, level clear and reload.
// Optional power pellets and fright timer are enabled with `define POWER_PELLET_EN.
module dot_level_controller #(
  parameter int unsigned POINTS_PER_DOT = 10,
  parameter int unsigned CLEAR_HOLD     = 60,
  parameter int unsigned SCORE_W        = 16,
  parameter int unsigned LEVEL_MAX      = 15
`ifdef POWER_PELLET_EN
  ,
  parameter int unsigned PELLET_POINTS  = 50,
  parameter int unsigned FRIGHT_TICKS   = 360
`endif
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               frame_tick,
  input  logic [143:0]       dot_start_map,
  input  logic [9:0]         pacX,
  input  logic [9:0]         pacY,
`ifdef POWER_PELLET_EN
  input  logic [143:0]       pellet_mask,
  output logic               frightened,
`endif
  output logic [143:0]       dot_map,
  output logic [7:0]         dots_left,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               eat_pulse,
  output logic               level_clear,
  output logic               playing
);

  localparam int unsigned HoldW = $clog2(CLEAR_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StClear} state_e;

  state_e             state_q, state_d;
  logic [7:0]         idx_q, idx_d;
  logic [143:0]       map_q, map_d;
  logic [7:0]         dots_q, dots_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         level_q, level_d;
  logic               eat_q, eat_d;
  logic               clr_q, clr_d;
  logic [HoldW-1:0]   hold_q, hold_d;

  logic [4:0]         row, col;
  logic               aligned, in_range, hit;
  logic [7:0]         tile, hit_bit;
  logic [SCORE_W:0]   pts, score_sum;
  logic [SCORE_W-1:0] score_sat;

  assign row      = pacY[9:5];
  assign col      = pacX[9:5];
  assign aligned  = (pacX[4:0] == 5'd0) && (pacY[4:0] == 5'd0);
  assign in_range = (row >= 5'd1) && (row <= 5'd12) && (col >= 5'd1) && (col <= 5'd12);
  assign tile     = ({3'b000, row} - 8'd1) * 8'd12 + ({3'b000, col} - 8'd1);
  assign hit_bit  = 8'd143 - tile;
  assign hit      = (state_q == StPlay) && (dots_q != 8'd0) && aligned && in_range &&
                    map_q[hit_bit];

`ifdef POWER_PELLET_EN
  localparam int unsigned FrightW = $clog2(FRIGHT_TICKS + 1);
  logic [FrightW-1:0] fright_q, fright_d;
  logic               pellet_hit;

  assign pellet_hit = hit && pellet_mask[hit_bit];
  assign pts = pellet_hit ? (SCORE_W+1)'(PELLET_POINTS) : (SCORE_W+1)'(POINTS_PER_DOT);
  assign frightened = (fright_q != '0);

  always_comb begin
    fright_d = fright_q;
    if (frame_tick && (fright_q != '0)) fright_d = fright_q - 1'b1;
    if (pellet_hit) fright_d = FrightW'(FRIGHT_TICKS);
    if ((state_d == StLoad) && (state_q != StLoad)) fright_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) fright_q <= '0;
    else          fright_q <= fright_d;
  end
`else
  assign pts = (SCORE_W+1)'(POINTS_PER_DOT);
`endif

  assign score_sum = {1'b0, score_q} + pts;
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    map_d   = map_q;
    dots_d  = dots_q;
    score_d = score_q;
    level_d = level_q;
    hold_d  = hold_q;
    eat_d   = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          score_d = '0;
          level_d = 4'd1;
          dots_d  = 8'd0;
          map_d   = '0;
          idx_d   = 8'd0;
        end
      end
      StLoad: begin
        map_d[8'd143 - idx_q] = dot_start_map[8'd143 - idx_q];
        dots_d = dots_q + {7'b0, dot_start_map[8'd143 - idx_q]};
        idx_d  = idx_q + 8'd1;
        if (idx_q == 8'd143) begin
          state_d = StPlay;
          idx_d   = 8'd0;
        end
      end
      StPlay: begin
        if (dots_q == 8'd0) begin
          state_d = StClear;
          clr_d   = 1'b1;
          hold_d  = '0;
        end else if (hit) begin
          map_d[hit_bit] = 1'b0;
          dots_d  = dots_q - 8'd1;
          score_d = score_sat;
          eat_d   = 1'b1;
        end
      end
      StClear: begin
        if (frame_tick) begin
          if (hold_q == HoldW'(CLEAR_HOLD - 1)) begin
            state_d = StLoad;
            level_d = (level_q >= 4'(LEVEL_MAX)) ? level_q : level_q + 4'd1;
            idx_d   = 8'd0;
            dots_d  = 8'd0;
            map_d   = '0;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      idx_q   <= 8'd0;
      map_q   <= '0;
      dots_q  <= 8'd0;
      score_q <= '0;
      level_q <= 4'd0;
      eat_q   <= 1'b0;
      clr_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      map_q   <= map_d;
      dots_q  <= dots_d;
      score_q <= score_d;
      level_q <= level_d;
      eat_q   <= eat_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
    end
  end

  assign dot_map     = map_q;
  assign dots_left   = dots_q;
  assign score       = score_q;
  assign level       = level_q;
  assign eat_pulse   = eat_q;
  assign level_clear = clr_q;
  assign playing     = (state_q == StPlay);

endmodule

// File: tb/tb_dot_level_controller.sv
// Randomized self-checking bench for dot_level_controller against a tile/score reference model.
module tb_dot_level_controller;

  logic         Clk = 1'b0;
  logic         Reset_n, start, frame_tick;
  logic [143:0] dot_start_map;
  logic [9:0]   pacX, pacY;
  logic [143:0] dot_map;
  logic [7:0]   dots_left;
  logic [15:0]  score;
  logic [3:0]   level;
  logic         eat_pulse, level_clear, playing;
`ifdef POWER_PELLET_EN
  logic [143:0] pellet_mask;
  logic         frightened;
`endif

  dot_level_controller dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .start         (start),
    .frame_tick    (frame_tick),
    .dot_start_map (dot_start_map),
    .pacX          (pacX),
    .pacY          (pacY),
`ifdef POWER_PELLET_EN
    .pellet_mask   (pellet_mask),
    .frightened    (frightened),
`endif
    .dot_map       (dot_map),
    .dots_left     (dots_left),
    .score         (score),
    .level         (level),
    .eat_pulse     (eat_pulse),
    .level_clear   (level_clear),
    .playing       (playing)
  );

  always #5 Clk = ~Clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_eat    = 0;
  logic [143:0] model_map;
  int           model_score;

  task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset_n = 1'b0;
    tick;
    tick;
    Reset_n = 1'b1;
  endtask

  // Pulse start and wait (bounded) for PLAY; n returns ticks taken including the start edge.
  task automatic start_game(output int n);
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    while (!playing && n < 400) begin
      tick;
      n++;
    end
    check_eq("reach_play", playing, 1'b1);
  endtask

  task automatic wait_play(output int n);
    n = 0;
    while (!playing && n < 400) begin
      tick;
      n++;
    end
    check_eq("reach_play", playing, 1'b1);
  endtask

  // One PLAY cycle: predict eating from tile rules, then compare all visible state.
  task automatic play_step(input int x, input int y);
    int   row, col, bi;
    logic hit;
    pacX = 10'(x);
    pacY = 10'(y);
    row  = y / 32;
    col  = x / 32;
    hit  = 1'b0;
    bi   = 0;
    if (x % 32 == 0 && y % 32 == 0 && row >= 1 && row <= 12 && col >= 1 && col <= 12) begin
      bi  = 143 - ((row - 1) * 12 + (col - 1));
      hit = model_map[bi];
    end
    tick;
    n_eat += int'(eat_pulse);
    check_eq("eat_pulse", eat_pulse, hit);
    if (hit) begin
      model_map[bi] = 1'b0;
      model_score  += 10;
    end
    check_eq("dot_map", dot_map, model_map);
    check_eq("score", score, 144'(model_score));
    check_eq("dots_left", dots_left, 144'($countones(model_map)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, clr_cnt, exp_level;
    logic [143:0] m;
    Reset_n = 1'b1; start = 1'b0; frame_tick = 1'b0;
    dot_start_map = '0; pacX = '0; pacY = '0;
`ifdef POWER_PELLET_EN
    pellet_mask = '0;
`endif

    // Reset state
    do_reset;
    check_eq("rst_dot_map", dot_map, '0);
    check_eq("rst_dots_left", dots_left, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_flags", {eat_pulse, level_clear, playing}, 0);
`ifdef POWER_PELLET_EN
    check_eq("rst_fright", frightened, 0);
`endif

    // Full map load: PLAY exactly 145 cycles after start
    dot_start_map = '1;
    start_game(n);
    check_eq("load_latency", 144'(n), 145);
    check_eq("load_dots", dots_left, 144);
    check_eq("load_map", dot_map, '1);
    check_eq("load_level", level, 1);
    model_map   = '1;
    model_score = 0;

    // Parked on tile (1,1): exactly one eat
    n_eat = 0;
    for (int i = 0; i < 6; i++) play_step(32, 32);
    check_eq("park_eats", 144'(n_eat), 1);
    check_eq("bit143", dot_map[143], 1'b0);

    // Unaligned and out-of-range positions
    play_step(33, 32);
    play_step(0, 0);
    play_step(416, 32);
    play_step(32, 416);
    play_step(64, 65);

    // Random map, random walk with start/frame_tick noise
    do_reset;
    for (int i = 0; i < 144; i++) m[i] = 1'($urandom_range(0, 1));
    m[100] = 1'b1;
    dot_start_map = m;
    start_game(n);
    model_map   = m;
    model_score = 0;
    check_eq("rnd_load_map", dot_map, m);
    check_eq("rnd_load_dots", dots_left, 144'($countones(m)));
    for (int i = 0; i < 400; i++) begin
      start      = 1'($urandom_range(0, 1));
      frame_tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) play_step($urandom_range(0, 1023), $urandom_range(0, 1023));
      else play_step(32 * $urandom_range(0, 13), 32 * $urandom_range(0, 13));
    end
    start = 1'b0; frame_tick = 1'b0;

    // Repeated level clears with a single-dot map, checking hold length and level saturation
    do_reset;
    dot_start_map = 144'h1;
    pacX = 10'd0; pacY = 10'd0;
    start_game(n);
    check_eq("one_dot_left", dots_left, 1);
    exp_level   = 1;
    model_score = 0;
    for (int lv = 0; lv < 16; lv++) begin
      check_eq("lvl_level", level, 144'(exp_level));
      pacX = 10'd384; pacY = 10'd384;
      tick;
      pacX = 10'd0; pacY = 10'd0;
      model_score += 10;
      check_eq("lvl_eat", eat_pulse, 1'b1);
      check_eq("lvl_score", score, 144'(model_score));
      check_eq("lvl_dots0", dots_left, 0);
      clr_cnt = 0;
      for (int k = 0; k < 4; k++) begin
        tick;
        clr_cnt += int'(level_clear);
      end
      check_eq("lvl_clear_pulse", 144'(clr_cnt), 1);
      check_eq("lvl_not_playing", playing, 1'b0);
      for (int k = 1; k <= 60; k++) begin
        frame_tick = 1'b1;
        tick;
        frame_tick = 1'b0;
        if (k == 59) check_eq("hold_level", level, 144'(exp_level));
        if (k < 60) begin
          n = $urandom_range(0, 2);
          for (int j = 0; j < n; j++) tick;
        end
      end
      exp_level = (exp_level < 15) ? exp_level + 1 : 15;
      check_eq("next_level", level, 144'(exp_level));
      check_eq("clear_dots_reset", dots_left, 0);
      wait_play(n);
      check_eq("reload_latency", 144'(n), 144);
      check_eq("reload_dots", dots_left, 1);
      check_eq("reload_score", score, 144'(model_score));
    end

    // Reset in the middle of LOAD at index 70
    do_reset;
    dot_start_map = '1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 70; i++) tick;
    check_eq("midload_partial", dots_left, 70);
    Reset_n = 1'b0;
    tick;
    Reset_n = 1'b1;
    check_eq("midrst_map", dot_map, '0);
    check_eq("midrst_dots", dots_left, 0);
    check_eq("midrst_score", score, 0);
    check_eq("midrst_level", level, 0);
    check_eq("midrst_playing", playing, 1'b0);

`ifdef POWER_PELLET_EN
    // Pellet at tile (1,1): 50 points and 360 frame_ticks of fright
    do_reset;
    dot_start_map = '1;
    pellet_mask   = '0;
    pellet_mask[143] = 1'b1;
    start_game(n);
    pacX = 10'd32; pacY = 10'd32;
    tick;
    pacX = 10'd0; pacY = 10'd0;
    check_eq("pellet_score", score, 50);
    check_eq("fright_on", frightened, 1'b1);
    for (int k = 1; k <= 360; k++) begin
      frame_tick = 1'b1;
      tick;
      frame_tick = 1'b0;
      if (k == 359) check_eq("fright_359", frightened, 1'b1);
    end
    check_eq("fright_off", frightened, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
